issue_id_allocator: RTL
=======================

ISSUE_ID_ALLOCATOR -- requirements
Module: issue_id_allocator

Interface
REQ-001 Parameter NUM_PORTS, default 4: issue slots per cycle, one ID per slot.
REQ-002 Parameter ID_WIDTH, default 6: issue-ID width; capacity CAP = 2^(ID_WIDTH-1) outstanding IDs, which keeps MSB-of-difference ordering valid for the downstream lock arbiter.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 alloc_req[NUM_PORTS]  input  1 each  slot i requests an ID this cycle.
REQ-006 alloc_gnt[NUM_PORTS]  output  1 each  slot i is granted an ID this cycle (combinational).
REQ-007 alloc_id[NUM_PORTS]  output  ID_WIDTH each  ID for slot i; valid only when alloc_gnt[i]=1, else 0.
REQ-008 retire_cnt  input  $clog2(NUM_PORTS+1)  number of oldest outstanding IDs retired this cycle.
REQ-009 flush  input  1  cancel all outstanding unretired IDs.
REQ-010 head_id  output  ID_WIDTH  oldest outstanding ID (registered).
REQ-011 tail_id  output  ID_WIDTH  next ID to allocate (registered).
REQ-012 inflight_cnt  output  ID_WIDTH  outstanding IDs, 0..CAP (registered).
REQ-013 full / empty  output  1 each  inflight_cnt==CAP / inflight_cnt==0.
REQ-014 err_underflow  output  1  sticky flag: retire_cnt exceeded inflight_cnt.

Function
REQ-015 free = CAP - inflight_cnt (registered value only); retires in the current cycle free slots from the next cycle onward, never in the same cycle.
REQ-016 Requesting slots are ranked in ascending index order; non-requesting slots are skipped and do not block higher-indexed slots.
REQ-017 The first min(free, number of requesters) requesting slots in rank order are granted; every later requester is denied.
REQ-018 The k-th granted slot (k=0,1,...) gets alloc_id = tail_id + k, modulo 2^ID_WIDTH (natural wrap).
REQ-019 Grant and ID outputs depend only on alloc_req, flush and registered state; no path from retire_cnt.
REQ-020 Effective retire r = min(retire_cnt, inflight_cnt); when retire_cnt > inflight_cnt, err_underflow sets and stays 1 until reset.
REQ-021 No flush: head_id <= head_id + r; tail_id <= tail_id + granted count; inflight_cnt <= inflight_cnt - r + granted count.
REQ-022 Flush: all alloc_gnt forced 0 that cycle; retire applies first (head_id <= head_id + r); then tail_id <= new head_id and inflight_cnt <= 0.
REQ-023 Simultaneous allocate and retire in one cycle: both applied per REQ-021; inflight_cnt never exceeds CAP and never goes below 0.
REQ-024 Invariant: tail_id - head_id (mod 2^ID_WIDTH) == inflight_cnt at all times.
REQ-025 full and empty derive combinationally from registered inflight_cnt.

Reset
REQ-026 rst_n low: head_id=0, tail_id=0, inflight_cnt=0, empty=1, full=0, err_underflow=0, all alloc_gnt=0, all alloc_id=0 immediately (asynchronous), regardless of inputs.
REQ-027 Reset asserted mid-operation discards all outstanding IDs; the first grant after release is ID 0.
REQ-028 After rst_n deasserts, grants are possible in the first clock cycle.

Verification (NUM_PORTS=4, ID_WIDTH=6, CAP=32)
REQ-029 Post-reset, alloc_req=1111 -> alloc_gnt=1111, ids 0,1,2,3; next cycle tail_id=4, inflight_cnt=4.
REQ-030 alloc_req=1011 (slot1 idle), tail_id=0 -> gnt=1011, slot0 id 0, slot2 id 1, slot3 id 2.
REQ-031 inflight_cnt=30, alloc_req=1111, retire_cnt=2 -> gnt=1100 only; next cycle inflight_cnt=30, full=0.
REQ-032 tail_id=62, head_id=40, alloc_req=1111 -> ids 62,63,0,1; next cycle tail_id=2, inflight_cnt=26.
REQ-033 head_id=5, inflight_cnt=10, flush=1, retire_cnt=2, alloc_req=1111 -> gnt=0000; next cycle head_id=7, tail_id=7, inflight_cnt=0, empty=1.
REQ-034 inflight_cnt=1, retire_cnt=3 -> next cycle inflight_cnt=0, head_id advanced by 1, err_underflow=1, held until rst_n low.

Source files
------------

// File: rtl/issue_id_allocator_if.sv
// ---------------------------------------------------------------------------
// issue_id_allocator_if
// Groups the per-cycle allocate/retire/flush traffic between the issue stage
// (master) and the issue-ID allocator (slave).
//
// Signals:
//   alloc_req  [NUM_PORTS]        master -> slave  slot i wants an ID
//   alloc_gnt  [NUM_PORTS]        slave  -> master slot i got an ID
//   alloc_id   [NUM_PORTS] x W    slave  -> master ID for slot i (0 if denied)
//   retire_cnt clog2(NUM_PORTS+1) master -> slave  oldest IDs retired
//   flush                         master -> slave  cancel outstanding IDs
// ---------------------------------------------------------------------------
interface issue_id_allocator_if #(
    parameter int NUM_PORTS = 4,
    parameter int ID_WIDTH  = 6
);
    localparam int RW = $clog2(NUM_PORTS + 1);

    logic [NUM_PORTS-1:0] alloc_req;
    logic [NUM_PORTS-1:0] alloc_gnt;
    logic [ID_WIDTH-1:0]  alloc_id [NUM_PORTS];
    logic [RW-1:0]        retire_cnt;
    logic                 flush;

    modport master (
        output alloc_req,
        output retire_cnt,
        output flush,
        input  alloc_gnt,
        input  alloc_id
    );

    modport slave (
        input  alloc_req,
        input  retire_cnt,
        input  flush,
        output alloc_gnt,
        output alloc_id
    );
endinterface

// File: rtl/issue_id_allocator.sv
// ---------------------------------------------------------------------------
// issue_id_allocator
// Hands out monotonically increasing issue IDs to up to NUM_PORTS slots per
// cycle, tracks the oldest outstanding ID, and retires/flushes them. At most
// CAP = 2^(ID_WIDTH-1) IDs are outstanding so that MSB-of-difference age
// comparison stays valid downstream.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   alloc_if       slave modport: alloc_req/gnt/id, retire_cnt, flush
//   head_id        oldest outstanding ID (registered)
//   tail_id        next ID to allocate (registered)
//   inflight_cnt   outstanding IDs, 0..CAP (registered)
//   full / empty   inflight_cnt == CAP / inflight_cnt == 0
//   err_underflow  sticky: a retire asked for more IDs than were outstanding
// ---------------------------------------------------------------------------
module issue_id_allocator #(
    parameter int NUM_PORTS = 4,
    parameter int ID_WIDTH  = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    issue_id_allocator_if.slave alloc_if,
    output logic [ID_WIDTH-1:0] head_id,
    output logic [ID_WIDTH-1:0] tail_id,
    output logic [ID_WIDTH-1:0] inflight_cnt,
    output logic                full,
    output logic                empty,
    output logic                err_underflow
);
    localparam logic [ID_WIDTH-1:0] CAP = {1'b1, {(ID_WIDTH-1){1'b0}}};

    logic [ID_WIDTH-1:0] free_slots;
    logic [ID_WIDTH-1:0] gnt_count;
    logic [NUM_PORTS-1:0] gnt_vec;
    logic [ID_WIDTH-1:0] id_arr [NUM_PORTS];
    logic [ID_WIDTH-1:0] retire_ext;
    logic [ID_WIDTH-1:0] retire_eff;
    logic [ID_WIDTH-1:0] head_next;

    // Free space comes only from registered occupancy; a retire this cycle
    // does not open slots until the next cycle, keeping retire_cnt off the
    // grant path.
    assign free_slots = CAP - inflight_cnt;

    // Grant requesters in ascending slot order until free space runs out.
    // Idle slots are skipped, so the k-th granted slot gets tail_id + k.
    // Grants are gated by rst_n so they drop immediately on reset.
    always_comb begin
        gnt_count = '0;
        gnt_vec   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            id_arr[i] = '0;
            if (rst_n && !alloc_if.flush && alloc_if.alloc_req[i] &&
                (gnt_count < free_slots)) begin
                gnt_vec[i] = 1'b1;
                id_arr[i]  = tail_id + gnt_count;
                gnt_count  = gnt_count + 1'b1;
            end
        end
    end

    assign alloc_if.alloc_gnt = gnt_vec;
    assign alloc_if.alloc_id  = id_arr;

    // Retire is clamped to what is actually outstanding; the excess only
    // raises the sticky error flag.
    assign retire_ext = ID_WIDTH'(alloc_if.retire_cnt);
    assign retire_eff = (retire_ext > inflight_cnt) ? inflight_cnt : retire_ext;
    assign head_next  = head_id + retire_eff;

    // Pointer and occupancy update. On flush the retire still lands first,
    // then the tail collapses onto the new head, discarding the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_id       <= '0;
            tail_id       <= '0;
            inflight_cnt  <= '0;
            err_underflow <= 1'b0;
        end else begin
            head_id <= head_next;
            if (alloc_if.flush) begin
                tail_id      <= head_next;
                inflight_cnt <= '0;
            end else begin
                tail_id      <= tail_id + gnt_count;
                inflight_cnt <= inflight_cnt - retire_eff + gnt_count;
            end
            if (retire_ext > inflight_cnt) begin
                err_underflow <= 1'b1;
            end
        end
    end

    assign full  = (inflight_cnt == CAP);
    assign empty = (inflight_cnt == '0);

endmodule
